// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD-line PHY, serializes a 48-bit command with CRC7 and captures the 48/136-bit response.
// Optional: define SD_RESP_CRC_CHECK_EN to enable receive CRC7 checking (otherwise crc_err is tied to 0).
module sd_cmd_phy #(
  parameter int TIMEOUT_TICKS = 64,
  parameter int NCR_MIN = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sd_tick,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  input  logic         cmd_pin_in,
  output logic [127:0] response,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         end_bit_err,
  output logic         index_err
);
  localparam logic [2:0] IDLE = 3'd0, TX = 3'd1, WAIT = 3'd2, RX = 3'd3, FINISH = 3'd4;
  localparam logic [7:0] TO = 8'(TIMEOUT_TICKS), NM = 8'(NCR_MIN);
  logic [2:0]   state;
  logic [5:0]   idx_q;
  logic [1:0]   type_q;
  logic [47:0]  tx_sr;
  logic [7:0]   cnt, wait_n, rx_last;
  logic [127:0] rx_sr, rx_nx;
  logic         accept;
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:3], c[2] ^ c[6] ^ b, c[1:0], c[6] ^ b};
  endfunction
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction
  always_comb begin
    cmd_ready = state == IDLE;
    done = state == FINISH;
    accept = cmd_ready & cmd_valid;
    rx_nx = {rx_sr[126:0], cmd_pin_in};
    wait_n = cnt + 8'd1;
    rx_last = type_q == 2'b10 ? 8'd135 : 8'd47;
  end
  // One shared counter: TX bit count, WAIT tick count, then RX bit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cmd_pin_out <= 1'b1;
      cmd_oe <= 1'b0;
      response <= '0;
      timeout_err <= 1'b0;
      end_bit_err <= 1'b0;
      index_err <= 1'b0;
      idx_q <= '0;
      type_q <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cnt <= '0;
    end else if (accept) begin
      state <= TX;
      idx_q <= cmd_index;
      type_q <= resp_type;
      tx_sr <= {2'b01, cmd_index, cmd_arg, crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
      cnt <= '0;
      rx_sr <= '0;
      response <= '0;
      timeout_err <= 1'b0;
      end_bit_err <= 1'b0;
      index_err <= 1'b0;
    end else if (state == FINISH) begin
      state <= IDLE;
    end else if (sd_tick) begin
      case (state)
        TX: if (cnt == 8'd48) begin
          cmd_oe <= 1'b0;
          cmd_pin_out <= 1'b1;
          cnt <= '0;
          state <= type_q == 2'b00 ? FINISH : WAIT;
        end else begin
          cmd_oe <= 1'b1;
          cmd_pin_out <= tx_sr[47];
          tx_sr <= {tx_sr[46:0], 1'b0};
          cnt <= cnt + 8'd1;
        end
        WAIT: begin
          cnt <= wait_n;
          if (wait_n > NM && !cmd_pin_in) begin
            state <= RX;
            cnt <= 8'd1;
            rx_sr <= rx_nx;
          end else if (wait_n == TO) begin
            timeout_err <= 1'b1;
            state <= FINISH;
          end
        end
        RX: begin
          rx_sr <= rx_nx;
          cnt <= cnt + 8'd1;
          if (cnt == rx_last) begin
            state <= FINISH;
            response <= type_q == 2'b10 ? {8'b0, rx_nx[127:8]} : {96'b0, rx_nx[39:8]};
            end_bit_err <= ~cmd_pin_in;
            index_err <= type_q == 2'b01 && rx_nx[45:40] != idx_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       in_crc;
  always_comb in_crc = type_q == 2'b10 ? (cnt >= 8'd8 && cnt <= 8'd127) : (cnt >= 8'd1 && cnt <= 8'd39);
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      rx_crc <= '0;
      crc_err <= 1'b0;
    end else if (state == RX && sd_tick) begin
      if (in_crc) rx_crc <= crc7_step(rx_crc, cmd_pin_in);
      if (cnt == rx_last) crc_err <= type_q != 2'b11 && rx_crc != rx_nx[7:1];
    end
  end
`else
  always_comb crc_err = 1'b0;
`endif
endmodule
